// File: rtl/ysyx_25040105_mem_arb.sv
// Two-master (IFU/LSU), one-slave memory arbiter.
// One outstanding transaction at a time. Round-robin on conflict.
// A per-transaction timeout returns an error response to the owner.
module ysyx_25040105_mem_arb #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Last counter value before the timeout fires; unused when TIMEOUT == 0.
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_owner;      // 0 = IFU, 1 = LSU; doubles as last_grant
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic               r_wen;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wmask;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic               w_grant_ifu;
  logic               w_grant_lsu;
  logic               w_timeout;
  logic               w_resp_take;
  logic               w_to_fire;

  // LSU wins a conflict when IFU was granted last; grants are suppressed while reset is held.
  assign w_grant_lsu = rst && (r_state == S_IDLE) && lsu_req_valid
                       && (!ifu_req_valid || !r_owner);
  assign w_grant_ifu = rst && (r_state == S_IDLE) && ifu_req_valid && !w_grant_lsu;

  assign w_timeout   = TO_EN && (r_cnt == TO_LAST);
  assign w_resp_take = (r_state == S_WAIT) && mem_resp_valid;
  // A handshake or response in the last allowed cycle beats the timeout.
  assign w_to_fire   = w_timeout &&
                       (((r_state == S_REQ)  && !mem_req_ready) ||
                        ((r_state == S_WAIT) && !mem_resp_valid));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic and control outputs.
  always_comb begin
    w_next_state   = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_resp_err   = 1'b0;
    lsu_resp_err   = 1'b0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        ifu_req_ready = w_grant_ifu;
        lsu_req_ready = w_grant_lsu;
        if (w_grant_ifu || w_grant_lsu) w_next_state = S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)  w_next_state = S_WAIT;
        else if (w_to_fire) w_next_state = S_RESP;
      end
      S_WAIT: begin
        if (mem_resp_valid) w_next_state = S_RESP;
        else if (w_to_fire) w_next_state = S_RESP;
      end
      S_RESP: begin
        ifu_resp_valid = !r_owner;
        lsu_resp_valid = r_owner;
        ifu_resp_err   = !r_owner && r_err;
        lsu_resp_err   = r_owner && r_err;
        w_next_state   = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the granted request; IFU fetches are forced to read with no strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_lsu) begin
      r_owner <= 1'b1;
      r_addr  <= lsu_req_addr;
      r_wen   <= lsu_req_wen;
      r_wdata <= lsu_req_wdata;
      r_wmask <= lsu_req_wmask;
    end else if (w_grant_ifu) begin
      r_owner <= 1'b0;
      r_addr  <= ifu_req_addr;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end
  end

  // Timeout counter: cleared on grant, counts every REQ and WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_grant_ifu || w_grant_lsu) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response capture: slave data/err, or a zero-data error on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_resp_take) begin
      r_rdata <= mem_resp_data;
      r_err   <= mem_resp_err;
    end else if (w_to_fire) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign ifu_resp_data = r_rdata;
  assign lsu_resp_data = r_rdata;
  assign owner         = r_owner;

endmodule

// File: tb/tb_ysyx_25040105_mem_arb.sv
// Directed testbench for ysyx_25040105_mem_arb.
// dut runs with the timeout disabled; u_to shares the inputs and uses TIMEOUT = 8.
module tb_ysyx_25040105_mem_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  logic        ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_wen, busy, owner;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;

  logic        t_ifu_req_ready, t_ifu_resp_valid, t_ifu_resp_err;
  logic [31:0] t_ifu_resp_data;
  logic        t_lsu_req_ready, t_lsu_resp_valid, t_lsu_resp_err;
  logic [31:0] t_lsu_resp_data;
  logic        t_mem_req_valid, t_mem_req_wen, t_busy, t_owner;
  logic [31:0] t_mem_req_addr, t_mem_req_wdata;
  logic [3:0]  t_mem_req_wmask;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_25040105_mem_arb #(.TIMEOUT(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .busy(busy), .owner(owner)
  );

  ysyx_25040105_mem_arb #(.TIMEOUT(8), .CNT_W(8)) u_to (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(t_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(t_ifu_resp_valid), .ifu_resp_data(t_ifu_resp_data), .ifu_resp_err(t_ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(t_lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(t_lsu_resp_valid), .lsu_resp_data(t_lsu_resp_data), .lsu_resp_err(t_lsu_resp_err),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(t_mem_req_addr),
    .mem_req_wen(t_mem_req_wen), .mem_req_wdata(t_mem_req_wdata), .mem_req_wmask(t_mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .busy(t_busy), .owner(t_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive point: just after the rising edge. Checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    #12;
    n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_errors++;
      $display("FAIL reset_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready}); end
    n_checks++; if ({mem_req_valid, busy, owner, ifu_resp_valid, lsu_resp_valid} !== 5'b0) begin n_errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req_valid, busy, owner, ifu_resp_valid, lsu_resp_valid}); end
    n_checks++; if ({mem_req_addr, mem_req_wdata, ifu_resp_data} !== 96'h0) begin n_errors++;
      $display("FAIL reset_data: got %h expected 0", {mem_req_addr, mem_req_wdata, ifu_resp_data}); end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_conflict();
    bit exp_lsu;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wen = 1'b1; lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_lsu = (k % 2 == 0);
      @(negedge clk);
      n_checks++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin n_errors++;
        $display("FAIL conflict_grant[%0d]: got lsu/ifu ready %b expected %b", k,
                 {lsu_req_ready, ifu_req_ready}, {exp_lsu, !exp_lsu}); end
      tick();
      mem_req_ready = 1'b1;
      @(negedge clk);
      n_checks++; if ({owner, mem_req_wen, mem_req_valid, ifu_req_ready, lsu_req_ready} !== {exp_lsu, exp_lsu, 3'b100}) begin n_errors++;
        $display("FAIL conflict_req[%0d]: got %b expected %b", k,
                 {owner, mem_req_wen, mem_req_valid, ifu_req_ready, lsu_req_ready}, {exp_lsu, exp_lsu, 3'b100}); end
      if (k == 0) begin
        n_checks++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask} !== {32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin n_errors++;
          $display("FAIL conflict_lsu_fields: got %h %h %h expected 80001000 deadbeef f", mem_req_addr, mem_req_wdata, mem_req_wmask); end
      end
      if (k == 1) begin
        n_checks++; if ({mem_req_addr, mem_req_wmask} !== {32'h8000_0010, 4'h0}) begin n_errors++;
          $display("FAIL conflict_ifu_fields: got %h %h expected 80000010 0", mem_req_addr, mem_req_wmask); end
      end
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hA000_0000 + k;
      tick();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({lsu_resp_valid, ifu_resp_valid, ifu_resp_data} !== {exp_lsu, !exp_lsu, 32'hA000_0000 + k}) begin n_errors++;
        $display("FAIL conflict_resp[%0d]: got lsu/ifu %b%b data %h expected %b%b data %h", k,
                 lsu_resp_valid, ifu_resp_valid, ifu_resp_data, exp_lsu, !exp_lsu, 32'hA000_0000 + k); end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
    tick();
  endtask

  task automatic test_ifu_alone();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    @(negedge clk);
    n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_errors++;
      $display("FAIL ifu_alone_ready: got %b expected 10", {ifu_req_ready, lsu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin n_errors++;
      $display("FAIL ifu_alone_req: got v=%b a=%h w=%b m=%h expected 1 80000000 0 0", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask); end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0073;
    @(negedge clk);
    n_checks++; if (ifu_resp_valid !== 1'b0) begin n_errors++;
      $display("FAIL ifu_alone_early: got %b expected 0", ifu_resp_valid); end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'h0010_0073, 2'b00}) begin n_errors++;
      $display("FAIL ifu_alone_resp: got v=%b d=%h e=%b lsu=%b expected 1 00100073 0 0", ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid); end
    tick();
    @(negedge clk);
    n_checks++; if ({busy, ifu_resp_valid} !== 2'b00) begin n_errors++;
      $display("FAIL ifu_alone_idle: got %b expected 00", {busy, ifu_resp_valid}); end
    tick();
  endtask

  task automatic test_stall();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wmask = 4'h3;
    @(negedge clk);
    n_checks++; if (lsu_req_ready !== 1'b1) begin n_errors++;
      $display("FAIL stall_grant: got %b expected 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_req_ready = 1'b1;
      @(negedge clk);
      n_checks++; if ({mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata} !==
                      {1'b1, 1'b1, 4'h3, 32'h8000_2000, 32'hCAFE_F00D}) begin n_errors++;
        $display("FAIL stall_req_stable[%0d]: got %b %b %h %h %h expected 1 1 3 80002000 cafef00d", i,
                 mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata); end
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({busy, mem_req_valid, lsu_resp_valid} !== 3'b100) begin n_errors++;
        $display("FAIL stall_wait[%0d]: got %b expected 100", i, {busy, mem_req_valid, lsu_resp_valid}); end
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55AA_55AA; mem_resp_err = 1'b0;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({lsu_resp_valid, lsu_resp_err, ifu_resp_valid} !== 3'b100) begin n_errors++;
      $display("FAIL stall_resp: got %b expected 100", {lsu_resp_valid, lsu_resp_err, ifu_resp_valid}); end
    tick();
    tick();
  endtask

  task automatic test_lsu_err();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0; lsu_req_wmask = 4'h0;
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678; mem_resp_err = 1'b1;
    tick();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    @(negedge clk);
    n_checks++; if ({lsu_resp_valid, lsu_resp_err, lsu_resp_data, ifu_resp_valid} !== {2'b11, 32'h1234_5678, 1'b0}) begin n_errors++;
      $display("FAIL lsu_err_resp: got v=%b e=%b d=%h ifu=%b expected 1 1 12345678 0", lsu_resp_valid, lsu_resp_err, lsu_resp_data, ifu_resp_valid); end
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    @(negedge clk);
    n_checks++; if ({busy, lsu_resp_valid, lsu_resp_err, ifu_req_ready} !== 4'b0001) begin n_errors++;
      $display("FAIL lsu_err_recover: got %b expected 0001", {busy, lsu_resp_valid, lsu_resp_err, ifu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({ifu_resp_valid, ifu_resp_err, ifu_resp_data} !== {2'b10, 32'h0000_0013}) begin n_errors++;
      $display("FAIL lsu_err_next: got v=%b e=%b d=%h expected 1 0 00000013", ifu_resp_valid, ifu_resp_err, ifu_resp_data); end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    // Slave accepts, never responds: response must appear 8 cycles after REQ entry.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
    @(negedge clk);
    n_checks++; if (t_ifu_req_ready !== 1'b1) begin n_errors++;
      $display("FAIL timeout_grant: got %b expected 1", t_ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      n_checks++; if ({t_busy, t_ifu_resp_valid} !== 2'b10) begin n_errors++;
        $display("FAIL timeout_wait[N+%0d]: got %b expected 10", i, {t_busy, t_ifu_resp_valid}); end
      tick();
    end
    @(negedge clk);
    n_checks++; if ({t_ifu_resp_valid, t_ifu_resp_err, t_ifu_resp_data, t_lsu_resp_valid} !== {2'b11, 32'h0, 1'b0}) begin n_errors++;
      $display("FAIL timeout_resp: got v=%b e=%b d=%h lsu=%b expected 1 1 00000000 0", t_ifu_resp_valid, t_ifu_resp_err, t_ifu_resp_data, t_lsu_resp_valid); end
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if ({t_busy, t_ifu_resp_valid, t_lsu_resp_valid} !== 3'b000) begin n_errors++;
      $display("FAIL timeout_late_idle: got %b expected 000", {t_busy, t_ifu_resp_valid, t_lsu_resp_valid}); end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({t_busy, t_ifu_resp_valid, t_lsu_resp_valid} !== 3'b000) begin n_errors++;
      $display("FAIL timeout_late_drop: got %b expected 000", {t_busy, t_ifu_resp_valid, t_lsu_resp_valid}); end
    tick();
    // Slave never accepts: mem_req_valid held for 8 cycles, then dropped with an error response.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_4000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'h1111_2222; lsu_req_wmask = 4'hF;
    @(negedge clk);
    n_checks++; if (t_lsu_req_ready !== 1'b1) begin n_errors++;
      $display("FAIL timeout_req_grant: got %b expected 1", t_lsu_req_ready); end
    tick();
    lsu_req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_checks++; if ({t_mem_req_valid, t_lsu_resp_valid} !== 2'b10) begin n_errors++;
        $display("FAIL timeout_req_hold[N+%0d]: got %b expected 10", i, {t_mem_req_valid, t_lsu_resp_valid}); end
      tick();
    end
    @(negedge clk);
    n_checks++; if ({t_mem_req_valid, t_lsu_resp_valid, t_lsu_resp_err, t_lsu_resp_data} !== {3'b011, 32'h0}) begin n_errors++;
      $display("FAIL timeout_req_resp: got mv=%b v=%b e=%b d=%h expected 0 1 1 00000000", t_mem_req_valid, t_lsu_resp_valid, t_lsu_resp_err, t_lsu_resp_data); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    // dut still holds the LSU store from the previous scenario in REQ.
    mem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, mem_req_valid, owner} !== 3'b111) begin n_errors++;
      $display("FAIL rstwait_req: got %b expected 111", {busy, mem_req_valid, owner}); end
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, mem_req_valid} !== 2'b10) begin n_errors++;
      $display("FAIL rstwait_wait: got %b expected 10", {busy, mem_req_valid}); end
    #1;
    ifu_req_valid = 1'b1;
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_req_valid, busy, owner, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 7'b0) begin n_errors++;
      $display("FAIL rstwait_async_ctrl: got %b expected 0000000", {mem_req_valid, busy, owner, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}); end
    n_checks++; if ({mem_req_addr, mem_req_wen, mem_req_wmask, lsu_resp_data} !== 69'h0) begin n_errors++;
      $display("FAIL rstwait_async_data: got %h %b %h %h expected 0", mem_req_addr, mem_req_wen, mem_req_wmask, lsu_resp_data); end
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_DEAD;
    @(negedge clk);
    n_checks++; if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin n_errors++;
      $display("FAIL rstwait_stale0: got %b expected 000", {busy, ifu_resp_valid, lsu_resp_valid}); end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin n_errors++;
      $display("FAIL rstwait_stale1: got %b expected 000", {busy, ifu_resp_valid, lsu_resp_valid}); end
    tick();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_req_wen = 1'b0;
    @(negedge clk);
    n_checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin n_errors++;
      $display("FAIL rstwait_last_grant: got lsu/ifu %b expected 10", {lsu_req_ready, ifu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_ifu_alone();
    test_stall();
    test_lsu_err();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
